// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that multiplexes four byte requesters onto one UART transmitter,
// holding the grant for a whole message and pacing bytes on the transmitter's busy handshake.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT = 65535,
  parameter int unsigned GAP     = 0,
  parameter int unsigned HIWAIT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_ch,
  input  logic [3:0]  req_v,
  input  logic [3:0]  req_last,
  output logic [3:0]  req_rdy,
  output logic [3:0]  grant,
  output logic [7:0]  tx_ch,
  output logic        tx_chv,
  input  logic        tx_busy,
  output logic        timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 2);
  localparam int unsigned HW = $clog2(HIWAIT + 2);
  localparam int unsigned GW = $clog2(GAP + 2);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, GAPW} state_t;

  state_t        state, state_nxt;
  logic [1:0]    g, g_nxt;
  logic [1:0]    lg, lg_nxt;
  logic [3:0]    grant_nxt;
  logic [7:0]    tx_ch_nxt;
  logic          tx_chv_nxt;
  logic          last_r, last_nxt;
  logic          timeout_err_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic [HW-1:0] hi_cnt, hi_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [1:0]    pick;
  logic          pick_v;
  logic [7:0]    g_ch;

  assign g_ch = req_ch[{g, 3'b000} +: 8];

  // Rotating priority: lg+1 first, lg last; descending loop lets the nearest candidate win.
  always_comb begin
    logic [1:0] idx;
    pick   = 2'd0;
    pick_v = 1'b0;
    idx    = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = lg + 2'(k);
      if (req_v[idx]) begin
        pick   = idx;
        pick_v = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    g_nxt           = g;
    lg_nxt          = lg;
    grant_nxt       = grant;
    tx_ch_nxt       = tx_ch;
    tx_chv_nxt      = 1'b0;
    last_nxt        = last_r;
    timeout_err_nxt = timeout_err;
    to_nxt          = '0;
    hi_nxt          = '0;
    gap_nxt         = '0;
    req_rdy         = 4'd0;
    case (state)
      IDLE: begin
        if (pick_v) begin
          g_nxt     = pick;
          grant_nxt = 4'b0001 << pick;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (req_v[g]) begin
          to_nxt = to_cnt;
          if (!tx_busy) begin
            req_rdy[g] = 1'b1;
            tx_ch_nxt  = g_ch;
            tx_chv_nxt = 1'b1;
            last_nxt   = req_last[g];
            to_nxt     = '0;
            state_nxt  = WAIT_HI;
          end
        end else if (32'(to_cnt) + 32'd1 >= TIMEOUT) begin
          // Owner stalled mid-message: revoke and let the others in.
          grant_nxt       = 4'd0;
          lg_nxt          = g;
          timeout_err_nxt = 1'b1;
          state_nxt       = IDLE;
        end else begin
          to_nxt = to_cnt + TW'(1);
        end
      end
      WAIT_HI: begin
        if (tx_busy || (32'(hi_cnt) + 32'd1 >= HIWAIT)) begin
          state_nxt = WAIT_LO;
        end else begin
          hi_nxt = hi_cnt + HW'(1);
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (!last_r) begin
            state_nxt = SEND;
          end else begin
            lg_nxt    = g;
            grant_nxt = 4'd0;
            state_nxt = (GAP > 0) ? GAPW : IDLE;
          end
        end
      end
      GAPW: begin
        if (32'(gap_cnt) + 32'd1 >= GAP) begin
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt + GW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      g           <= 2'd0;
      lg          <= 2'd3;
      grant       <= 4'd0;
      tx_ch       <= 8'd0;
      tx_chv      <= 1'b0;
      last_r      <= 1'b0;
      timeout_err <= 1'b0;
      to_cnt      <= '0;
      hi_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      g           <= g_nxt;
      lg          <= lg_nxt;
      grant       <= grant_nxt;
      tx_ch       <= tx_ch_nxt;
      tx_chv      <= tx_chv_nxt;
      last_r      <= last_nxt;
      timeout_err <= timeout_err_nxt;
      to_cnt      <= to_nxt;
      hi_cnt      <= hi_nxt;
      gap_cnt     <= gap_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, a simple busy model,
// and a strobe log checked against hand-computed sequences and cycle offsets.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] req_ch;
  logic [3:0]  req_v;
  logic [3:0]  req_last;
  logic [3:0]  req_rdy;
  logic [3:0]  grant;
  logic [7:0]  tx_ch;
  logic        tx_chv;
  logic        tx_busy;
  logic        timeout_err;

  uart_tx_arbiter #(.TIMEOUT(8), .GAP(0), .HIWAIT(4)) dut (
    .clk(clk), .rst(rst), .req_ch(req_ch), .req_v(req_v), .req_last(req_last),
    .req_rdy(req_rdy), .grant(grant), .tx_ch(tx_ch), .tx_chv(tx_chv),
    .tx_busy(tx_busy), .timeout_err(timeout_err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [8:0] q [4][$];
  logic [7:0] log_b [$];
  logic [3:0] log_g [$];
  int         log_c [$];

  logic [3:0] rdy_s = 4'd0;
  bit         busy_en = 1'b0;
  int         busy_cnt = 0;
  int         bad_cnt = 0;
  logic [3:0] prev_g = 4'd0;
  logic       prev_chv = 1'b0;
  logic       prev_te = 1'b0;
  int         g_first = -1;
  int         r_first = -1;
  int         rise_cyc = -1;
  int         g_fall = -1;
  logic       te_fall = 1'b0;
  logic       te_before = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit, expected test completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requesters and busy model: update just after each rising edge.
  initial begin
    logic [3:0] prev_v;
    req_v = 4'd0; req_ch = 32'd0; req_last = 4'd0; tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < 4; i++)
        if (rdy_s[i] && q[i].size() > 0) void'(q[i].pop_front());
      prev_v = req_v;
      for (int i = 0; i < 4; i++) begin
        if (q[i].size() > 0) begin
          req_v[i]         = 1'b1;
          req_ch[8*i +: 8] = q[i][0][7:0];
          req_last[i]      = q[i][0][8];
        end else begin
          req_v[i]    = 1'b0;
          req_last[i] = 1'b0;
        end
      end
      if (prev_v == 4'd0 && req_v != 4'd0) rise_cyc = cyc;
      if (busy_en && busy_cnt > 0) begin
        tx_busy = 1'b1;
        busy_cnt--;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  // Monitor on the falling edge: strobe log, protocol sanity, event cycles.
  initial begin
    forever begin
      @(negedge clk);
      rdy_s = req_rdy;
      if (tx_chv) begin
        log_b.push_back(tx_ch);
        log_g.push_back(grant);
        log_c.push_back(cyc);
        if (busy_en) busy_cnt = 10;
      end
      if (tx_chv && prev_chv) bad_cnt++;
      if (grant != 4'd0 && prev_g != 4'd0 && grant != prev_g) bad_cnt++;
      if (!$onehot0(grant) || (req_rdy & ~grant) != 4'd0) bad_cnt++;
      if (grant != 4'd0 && g_first < 0) g_first = cyc;
      if (req_rdy != 4'd0 && r_first < 0) r_first = cyc;
      if (prev_g != 4'd0 && grant == 4'd0) begin
        g_fall    = cyc;
        te_fall   = timeout_err;
        te_before = prev_te;
      end
      prev_g   = grant;
      prev_chv = tx_chv;
      prev_te  = timeout_err;
    end
  end

  task automatic clear_log();
    log_b.delete(); log_g.delete(); log_c.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) q[i].delete();
    clear_log();
    busy_cnt = 0;
    repeat (2) @(negedge clk);
    #1;
    g_first = -1; r_first = -1; rise_cyc = -1; g_fall = -1;
    rst = 1'b0;
  endtask

  task automatic wait_log(input string tag, input int n);
    int k = 0;
    while (log_b.size() < n && k < 1000) begin @(negedge clk); k++; end
    #1;
    check({tag, "_log_wait"}, 32'(k < 1000), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int n);
    int k = 0;
    while (!(log_b.size() >= n && grant == 4'd0) && k < 1000) begin @(negedge clk); k++; end
    #1;
    check({tag, "_done"}, 32'(k < 1000), 32'd1);
  endtask

  task automatic check_log(input string tag, input int i, input logic [7:0] b, input logic [3:0] g);
    check({tag, "_byte"}, (i < log_b.size()) ? 32'(log_b[i]) : 32'hFFFF_FFFF, 32'(b));
    check({tag, "_owner"}, (i < log_g.size()) ? 32'(log_g[i]) : 32'hFFFF_FFFF, 32'(g));
  endtask

  initial begin
    logic [7:0] b4 [4];
    rst = 1'b1;

    // Reset state
    do_reset();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_tx_chv", 32'(tx_chv), 32'd0);
    check("rst_tx_ch", 32'(tx_ch), 32'd0);
    check("rst_rdy", 32'(req_rdy), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);

    // Single requester, 10-cycle busy after each strobe
    busy_en = 1'b1;
    q[1].push_back(9'h01B); q[1].push_back(9'h047); q[1].push_back(9'h140);
    wait_done("single", 3);
    check("single_count", 32'(log_b.size()), 32'd3);
    check_log("single0", 0, 8'h1B, 4'b0010);
    check_log("single1", 1, 8'h47, 4'b0010);
    check_log("single2", 2, 8'h40, 4'b0010);
    check("single_gap01", 32'(log_c[1] - log_c[0]), 32'd13);
    check("single_gap12", 32'(log_c[2] - log_c[1]), 32'd13);

    // All four at once: round-robin from requester 0
    do_reset();
    busy_en = 1'b0;
    for (int i = 0; i < 4; i++) q[i].push_back({1'b1, 8'hA0 + 8'(i)});
    wait_done("all4", 4);
    for (int i = 0; i < 4; i++) check_log("all4", i, 8'hA0 + 8'(i), 4'b0001 << i);

    // Message lock: requester 0 waits for requester 2's last byte
    do_reset();
    busy_en = 1'b1;
    q[2].push_back(9'h0C0); q[2].push_back(9'h0C1); q[2].push_back(9'h1C2);
    wait_log("lock", 1);
    q[0].push_back(9'h1D0);
    wait_done("lock", 4);
    check_log("lock0", 0, 8'hC0, 4'b0100);
    check_log("lock1", 1, 8'hC1, 4'b0100);
    check_log("lock2", 2, 8'hC2, 4'b0100);
    check_log("lock3", 3, 8'hD0, 4'b0001);

    // Timeout: requester 3 stalls after a non-last byte
    do_reset();
    busy_en = 1'b1;
    q[3].push_back(9'h0E5);
    wait_done("tmo", 1);
    check_log("tmo0", 0, 8'hE5, 4'b1000);
    check("tmo_revoke_cycle", 32'(g_fall - log_c[0]), 32'd20);
    check("tmo_err_set", 32'(te_fall), 32'd1);
    check("tmo_err_before", 32'(te_before), 32'd0);
    q[3].push_back(9'h1F3); q[0].push_back(9'h1F0);
    wait_done("tmo_next", 3);
    check_log("tmo1", 1, 8'hF0, 4'b0001);
    check_log("tmo2", 2, 8'hF3, 4'b1000);
    check("tmo_err_sticky", 32'(timeout_err), 32'd1);

    // Busy never rises: latency and HIWAIT+2 strobe spacing
    do_reset();
    busy_en = 1'b0;
    b4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    q[1].push_back(9'h011); q[1].push_back(9'h022); q[1].push_back(9'h033); q[1].push_back(9'h144);
    wait_done("nobusy", 4);
    check("lat_grant", 32'(g_first - rise_cyc), 32'd1);
    check("lat_rdy", 32'(r_first - rise_cyc), 32'd1);
    check("lat_strobe", 32'(log_c[0] - rise_cyc), 32'd2);
    for (int i = 0; i < 4; i++) check_log("nobusy", i, b4[i], 4'b0010);
    for (int i = 1; i < 4; i++) check("nobusy_gap", 32'(log_c[i] - log_c[i-1]), 32'd6);

    // Reset mid-message
    do_reset();
    busy_en = 1'b0;
    q[2].push_back(9'h051); q[2].push_back(9'h052); q[2].push_back(9'h053); q[2].push_back(9'h154);
    wait_log("midrst", 2);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) q[i].delete();
    @(negedge clk);
    #1;
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_tx_chv", 32'(tx_chv), 32'd0);
    check("midrst_tx_ch", 32'(tx_ch), 32'd0);
    check("midrst_rdy", 32'(req_rdy), 32'd0);
    check("midrst_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    clear_log();
    q[3].push_back(9'h163); q[0].push_back(9'h160);
    wait_done("midrst", 2);
    check("midrst_count", 32'(log_b.size()), 32'd2);
    check_log("midrst0", 0, 8'h60, 4'b0001);
    check_log("midrst1", 1, 8'h63, 4'b1000);

    check("protocol_violations", 32'(bad_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
